// File: rtl/mux_tree_pkg.sv
// Shared helpers and limits for the pipelined mux tree.
package mux_tree_pkg;
  localparam int MAX_N_IN = 256;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/mux_tree_level.sv
// One tree level: N_OPER/2 2:1 selects feeding a valid/ready register slice.
module mux_tree_level import mux_tree_pkg::*; #(
  parameter int N_OPER = 2,
  parameter int DATA_W = 1,
  parameter int SEL_W  = 1
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_OPER*DATA_W-1:0]   in_data,
  input  logic [SEL_W-1:0]           in_sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [N_OPER/2*DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]           out_sel,
  output logic                       out_valid,
  input  logic                       out_ready
);
  // Depth position follows from operand count: the widest level consumes sel bit 0.
  localparam int BIT   = SEL_W - clog2(N_OPER);
  localparam int N_RES = N_OPER / 2;

  logic [N_RES*DATA_W-1:0] red;

  for (genvar j = 0; j < N_RES; j++) begin : g_pair
    assign red[j*DATA_W +: DATA_W] = in_sel[BIT] ? in_data[(2*j+1)*DATA_W +: DATA_W]
                                                 : in_data[(2*j)*DATA_W +: DATA_W];
  end

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= red;
        out_sel  <= in_sel;
      end
    end
  end
endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N_IN:1 mux tree, one register slice per level, valid/ready backpressure.
module mux_tree_pipe import mux_tree_pkg::*; #(
  parameter int N_IN   = 8,
  parameter int DATA_W = 1,
  parameter int LEVELS = clog2(N_IN)
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic [LEVELS-1:0]      in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [LEVELS-1:0]      out_sel,
  output logic                   out_valid,
  input  logic                   out_ready
);
  // All tree nodes live in one heap-ordered bus: level k inputs start at 2*N_IN - 2*(N_IN>>k).
  localparam int NODES = 2*N_IN - 1;

  if (N_IN < 2 || N_IN > MAX_N_IN || (N_IN & (N_IN - 1)) != 0) begin : g_bad_n_in
    $error("mux_tree_pipe: N_IN must be a power of two in [2, MAX_N_IN]");
  end
  if (LEVELS != clog2(N_IN)) begin : g_bad_levels
    $error("mux_tree_pipe: LEVELS is derived from N_IN and must not be overridden");
  end

  logic [NODES*DATA_W-1:0]     node;
  logic [LEVELS:0][LEVELS-1:0] sel_pipe;
  logic [LEVELS:0]             vld_pipe;
  logic [LEVELS:0]             rdy_pipe;

  assign node[N_IN*DATA_W-1:0] = in_data;
  assign sel_pipe[0]           = in_sel;
  assign vld_pipe[0]           = in_valid;
  assign rdy_pipe[LEVELS]      = out_ready;
  assign in_ready              = rdy_pipe[0];

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int N_OPER  = N_IN >> k;
    localparam int IN_OFF  = 2*N_IN - 2*N_OPER;
    localparam int OUT_OFF = IN_OFF + N_OPER;

    mux_tree_level #(
      .N_OPER (N_OPER),
      .DATA_W (DATA_W),
      .SEL_W  (LEVELS)
    ) u_lvl (
      .clk       (clk),
      .rst       (rst),
      .in_data   (node[IN_OFF*DATA_W +: N_OPER*DATA_W]),
      .in_sel    (sel_pipe[k]),
      .in_valid  (vld_pipe[k]),
      .in_ready  (rdy_pipe[k]),
      .out_data  (node[OUT_OFF*DATA_W +: N_OPER/2*DATA_W]),
      .out_sel   (sel_pipe[k+1]),
      .out_valid (vld_pipe[k+1]),
      .out_ready (rdy_pipe[k+1])
    );
  end

  assign out_data  = node[(NODES-1)*DATA_W +: DATA_W];
  assign out_sel   = sel_pipe[LEVELS];
  assign out_valid = vld_pipe[LEVELS];
endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: 8x8 directed table/sequences plus 2x1 and 32x16 random runs.
module tb_mux_tree_pipe;
  localparam int N = 8, W = 8, L = 3;
  localparam int BP_SEL [6] = '{5, 2, 7, 0, 3, 1};

  typedef struct { logic [W-1:0] data; logic [L-1:0] sel; } item_t;
  typedef struct { logic [N*W-1:0] data; logic [L-1:0] sel; logic [W-1:0] exp; } vec_t;

  logic clk = 1'b0, rst = 1'b1, r2 = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0, errors = 0;

  // main 8x8 instance
  logic [N*W-1:0] in_data = '0;
  logic [L-1:0]   in_sel = '0, out_sel;
  logic           in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [W-1:0]   out_data;

  mux_tree_pipe #(.N_IN(N), .DATA_W(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready));

  // 2x1 instance
  logic [1:0] b_data = '0;
  logic       b_sel = 1'b0, b_valid = 1'b0, b_ready, b_out_data, b_out_sel, b_out_valid;
  logic       b_out_ready = 1'b0;

  mux_tree_pipe #(.N_IN(2), .DATA_W(1)) dut_b (
    .clk(clk), .rst(r2), .in_data(b_data), .in_sel(b_sel), .in_valid(b_valid),
    .in_ready(b_ready), .out_data(b_out_data), .out_sel(b_out_sel), .out_valid(b_out_valid),
    .out_ready(b_out_ready));

  // 32x16 instance
  logic [511:0] c_data = '0;
  logic [4:0]   c_sel = '0, c_out_sel;
  logic [15:0]  c_out_data;
  logic         c_valid = 1'b0, c_ready, c_out_valid, c_out_ready = 1'b0;

  mux_tree_pipe #(.N_IN(32), .DATA_W(16)) dut_c (
    .clk(clk), .rst(r2), .in_data(c_data), .in_sel(c_sel), .in_valid(c_valid),
    .in_ready(c_ready), .out_data(c_out_data), .out_sel(c_out_sel), .out_valid(c_out_valid),
    .out_ready(c_out_ready));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bad(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: output with empty scoreboard (cycle %0d)", nm, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // main scoreboard
  item_t q[$];
  item_t pend, e;
  int out_n = 0, first_acc = -1, first_out = -1, last_out = -1;

  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) bad("main_sb");
        else begin
          e = q.pop_front();
          chk("sb_data", 64'(out_data), 64'(e.data));
          chk("sb_sel", 64'(out_sel), 64'(e.sel));
        end
        out_n++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      if (in_valid && in_ready) begin
        q.push_back(pend);
        if (first_acc < 0) first_acc = cyc;
      end
    end
  end

  // corner-instance scoreboards: {sel, data}
  logic [1:0]  bq[$];
  logic [20:0] cq[$];
  logic [1:0]  bexp;
  logic [20:0] cexp;

  always @(negedge clk) begin
    if (r2) begin
      bq.delete();
      cq.delete();
    end else begin
      if (b_out_valid && b_out_ready) begin
        if (bq.size() == 0) bad("b_sb");
        else begin bexp = bq.pop_front(); chk("b_sb", 64'({b_out_sel, b_out_data}), 64'(bexp)); end
      end
      if (b_valid && b_ready) bq.push_back({b_sel, b_data[b_sel]});
      if (c_out_valid && c_out_ready) begin
        if (cq.size() == 0) bad("c_sb");
        else begin cexp = cq.pop_front(); chk("c_sb", 64'({c_out_sel, c_out_data}), 64'(cexp)); end
      end
      if (c_valid && c_ready) cq.push_back({c_sel, c_data[c_sel*16 +: 16]});
    end
  end

  task automatic send(input logic [N*W-1:0] d, input logic [L-1:0] s, input logic [W-1:0] ex,
                      output int waits);
    logic acc;
    in_data = d; in_sel = s; pend.data = ex; pend.sel = s; in_valid = 1'b1; waits = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      if (!acc) waits++;
      tick();
    end while (!acc && waits < 100);
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n, input string nm);
    int t;
    t = 0;
    while (out_n < n && t < 200) begin tick(); t++; end
    chk(nm, 64'(out_n), 64'(n));
  endtask

  vec_t tv [12];
  logic [N*W-1:0] chan;
  int w, lat;
  logic b_acc, c_acc;

  initial begin
    for (int i = 0; i < N; i++) chan[i*W +: W] = 8'hA0 + 8'(i);
    for (int i = 0; i < 8; i++) tv[i] = '{chan, 3'(i), 8'hA0 + 8'(i)};
    tv[8]  = '{64'h0123456789ABCDEF, 3'd0, 8'hEF};
    tv[9]  = '{64'h0123456789ABCDEF, 3'd7, 8'h01};
    tv[10] = '{64'h0123456789ABCDEF, 3'd3, 8'h89};
    tv[11] = '{64'hFF00FF00FF00FF00, 3'd1, 8'hFF};

    // reset state
    tick();
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_sel", 64'(out_sel), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    tick();

    // table sweep, back-to-back with no stall
    out_ready = 1'b1; out_n = 0; first_acc = -1; first_out = -1;
    for (int i = 0; i < 12; i++) send(tv[i].data, tv[i].sel, tv[i].exp, w);
    wait_out(12, "table_count");
    chk("table_latency", 64'(first_out - first_acc), 64'(L));
    chk("table_back_to_back", 64'(last_out - first_out), 64'd11);

    // backpressure: stall output once the pipe has filled
    out_n = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(chan, 3'(BP_SEL[i]), 8'hA0 + 8'(BP_SEL[i]), w);
      end
      begin
        repeat (3) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("bp_out_valid", 64'(out_valid), 64'd1);
          chk("bp_hold_data", 64'(out_data), 64'hA5);
          chk("bp_hold_sel", 64'(out_sel), 64'd5);
          chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        tick();
        out_ready = 1'b1;
      end
    join
    wait_out(6, "bp_count");

    // bubble collapse: stalled output, empty stages still fill
    out_ready = 1'b0; out_n = 0;
    tick();
    send(chan, 3'd6, 8'hA6, w); chk("bub_wait0", 64'(w), 64'd0);
    send(chan, 3'd3, 8'hA3, w); chk("bub_wait1", 64'(w), 64'd0);
    send(chan, 3'd1, 8'hA1, w); chk("bub_wait2", 64'(w), 64'd0);
    @(negedge clk);
    chk("bub_full_in_ready", 64'(in_ready), 64'd0);
    tick();

    // full pipe: one in, one out each cycle
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = chan; in_sel = 3'(i + 2); pend.data = 8'hA2 + 8'(i); pend.sel = 3'(i + 2);
      in_valid = 1'b1;
      @(negedge clk);
      chk("full_in_ready", 64'(in_ready), 64'd1);
      chk("full_out_valid", 64'(out_valid), 64'd1);
      tick();
      chk("full_occupancy", 64'(q.size()), 64'd3);
    end
    in_valid = 1'b0;
    wait_out(7, "full_count");

    // reset with 3 items in flight
    out_ready = 1'b0; out_n = 0;
    for (int i = 0; i < 3; i++) send(chan, 3'(i + 4), 8'hA4 + 8'(i), w);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_data", 64'(out_data), 64'd0);
    chk("mid_rst_out_sel", 64'(out_sel), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    tick();
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_release_ready", 64'(in_ready), 64'd1);
    repeat (10) tick();
    chk("mid_rst_no_ghost", 64'(out_n), 64'd0);

    // width/depth corners
    tick();
    r2 = 1'b0;
    fork
      begin
        b_out_ready = 1'b1; b_valid = 1'b1; b_sel = 1'b1; b_data = 2'b10;
        @(negedge clk); chk("b_lat_accept", 64'(b_ready), 64'd1);
        lat = cyc; tick(); b_valid = 1'b0;
        for (int t = 0; t < 20 && !b_out_valid; t++) tick();
        @(negedge clk); chk("b_latency", 64'(cyc - lat), 64'd1);
        for (int i = 0; i < 10000; i++) begin
          @(negedge clk); b_acc = b_valid && b_ready;
          tick();
          if (!b_valid || b_acc) begin
            b_valid = 1'($urandom_range(0, 1)); b_data = 2'($urandom); b_sel = 1'($urandom);
          end
          b_out_ready = ($urandom_range(0, 3) != 0);
        end
        b_valid = 1'b0; b_out_ready = 1'b1;
        repeat (10) tick();
        chk("b_drained", 64'(bq.size()), 64'd0);
      end
      begin
        int clat;
        c_out_ready = 1'b1; c_valid = 1'b1; c_sel = 5'd19;
        for (int k = 0; k < 16; k++) c_data[k*32 +: 32] = $urandom;
        @(negedge clk); chk("c_lat_accept", 64'(c_ready), 64'd1);
        clat = cyc; tick(); c_valid = 1'b0;
        for (int t = 0; t < 20 && !c_out_valid; t++) tick();
        @(negedge clk); chk("c_latency", 64'(cyc - clat), 64'd5);
        for (int i = 0; i < 10000; i++) begin
          @(negedge clk); c_acc = c_valid && c_ready;
          tick();
          if (!c_valid || c_acc) begin
            c_valid = 1'($urandom_range(0, 1)); c_sel = 5'($urandom);
            for (int k = 0; k < 16; k++) c_data[k*32 +: 32] = $urandom;
          end
          c_out_ready = ($urandom_range(0, 3) != 0);
        end
        c_valid = 1'b0; c_out_ready = 1'b1;
        repeat (10) tick();
        chk("c_drained", 64'(cq.size()), 64'd0);
      end
    join

    chk("main_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
